flag_stack: RTL
===============

Name: flag_stack

Overview:
- Parametrised successor to the CPU status-flag register.
- Holds a FLAG_W-bit live flag vector with per-bit write masking.
- Adds a DEPTH-entry LIFO shadow stack so flags can be saved and restored on interrupt entry/return and nested calls.
- Sits between the ALU flag outputs and the control unit; supplies the carry-in to the ALU.

Parameters:
- FLAG_W, 4: width of the flag vector. Bit indices come from cpu_pkg: carry=0, zero=1, sign=2, overflow=3.
- DEPTH, 4: number of shadow-stack entries; must be ≥1.
- CNT_W, $clog2(DEPTH+1): width of the stack-depth counter (derived; do not override).

Ports:
- iclk  in  1  clock; all state updates on rising edge.
- irst_n  in  1  reset; synchronous, active-low.
- iclf  in  1  clear live flags.
- ien  in  1  write enable for live flags.
- iwmask  in  FLAG_W  per-bit write mask; 1 = bit updated when ien.
- iflag  in  FLAG_W  new flag values from the ALU.
- ipush  in  1  save live flags to the stack.
- ipop  in  1  restore live flags from the stack.
- iclr_err  in  1  clear the sticky error bits.
- iforce_carry  in  1  force ocarry to 0.
- oflag  out  FLAG_W  live flag register.
- ocarry  out  1  carry-in to the ALU.
- odepth  out  CNT_W  number of valid stack entries.
- oempty  out  1  odepth==0.
- ofull  out  1  odepth==DEPTH.
- oerr_ovf  out  1  sticky: push attempted while full.
- oerr_udf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (irst_n=0 at a clock edge): oflag=0, odepth=0, oerr_ovf=0, oerr_udf=0; stack contents don't-care.
- Combinational outputs:
  - ocarry = iforce_carry ? 0 : oflag[carry]; no register stage.
  - oempty and ofull decode combinationally from odepth.
- Live-flag priority per cycle, highest first:
  1. reset
  2. iclf: oflag ← 0; stack untouched, but push/pop still act on the stack
  3. valid pop: oflag ← stack top; ien ignored
  4. ien: oflag ← (oflag & ~iwmask) | (iflag & iwmask)
  5. hold
- Push:
  - Writes the pre-edge oflag into entry[odepth]; odepth+1.
  - Same-cycle ien updates oflag; the stack keeps the old value.
- Pop:
  - Loads entry[odepth-1] into oflag; odepth-1.
  - With iclf, the stack still pops but oflag ← 0.
- ipush & ipop together = exchange:
  - oflag ← top entry; top entry ← pre-edge oflag; odepth unchanged.
  - If empty: treated as a push only; oerr_udf set.
- Push while full: stack and odepth unchanged; oerr_ovf ← 1; live-flag update proceeds (ien/iclf).
- Pop while empty: odepth unchanged; oerr_udf ← 1; treated as no pop, so ien applies.
- Sticky errors:
  - Cleared by iclr_err.
  - A set event in the same cycle as iclr_err wins (bit reads 1).
- Reset mid-sequence discards all saved entries; no partial state survives.
- Latency: all updates visible on the cycle after the edge.

Optional Feature:
- Macro: FLAG_STACK_PARITY_EN.
- When defined:
  - Each stack entry stores an even-parity bit computed at push.
  - On pop or exchange, parity is checked on the entry read.
  - A mismatch sets a sticky output oerr_par (1 bit, reset 0, cleared by iclr_err); the data is still loaded.
- When undefined: no parity storage, and port oerr_par is absent.

Decomposition:
- cpu_pkg additions:
  - FLAG_W_DEF=4
  - flag index constants FLAG_CARRY_IDX, FLAG_ZERO_IDX, FLAG_SIGN_IDX, FLAG_OVF_IDX
  - typedef flag_vec_t (logic [FLAG_W_DEF-1:0])
- One sub-module, flag_stack_mem:
  - DEPTH×(FLAG_W[+1]) register array with write port (addr, data, we) and asynchronous read port.
  - No reset on storage.
- Top level owns the pointer, live flags, error logic and priority mux.

Test Plan:
- Masked write: oflag=0000, ien=1, iwmask=0011, iflag=1111 → oflag=0011; then iforce_carry=1 → ocarry=0, oflag unchanged.
- Nested save/restore, DEPTH=4:
  - oflag=0101, push, then ien iflag=1010 mask=1111 in the same cycle → oflag=1010, odepth=1.
  - Pop → oflag=0101, odepth=0, oempty=1.
- Overflow: push 5 times from empty → odepth=4, ofull=1, oerr_ovf=1 after the 5th; pops return the first four values LIFO; iclr_err → oerr_ovf=0.
- Underflow with write: empty, ipop=1 + ien iflag=0001 mask=1111 → oflag=0001, oerr_udf=1, odepth=0.
- Exchange and clear:
  - odepth=1, top=1100, oflag=0011, push+pop → oflag=1100, top=0011, odepth=1.
  - Then iclf+pop → oflag=0000, odepth=0.
- Reset mid-use: odepth=3, oerr_ovf=1, irst_n=0 one cycle → all outputs 0, oempty=1; a subsequent pop sets oerr_udf.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and types for the status-flag path
package cpu_pkg;

   localparam int FLAG_W_DEF     = 4;

   localparam int FLAG_CARRY_IDX = 0;
   localparam int FLAG_ZERO_IDX  = 1;
   localparam int FLAG_SIGN_IDX  = 2;
   localparam int FLAG_OVF_IDX   = 3;

   typedef logic [FLAG_W_DEF-1:0] flag_vec_t;

endpackage

// File: rtl/flag_stack_mem.sv
// rtl/flag_stack_mem.sv - shadow-stack storage, one write port and one asynchronous read port
module flag_stack_mem #(
   parameter int DEPTH = 4,
   parameter int W     = 4,
   parameter int AW    = 2
) (
   input  logic          iclk,
   input  logic          iwe,
   input  logic [AW-1:0] iwaddr,
   input  logic [W-1:0]  iwdata,
   input  logic [AW-1:0] iraddr,
   output logic [W-1:0]  ordata
);

   logic [W-1:0] mem [DEPTH];

   // Storage is never reset; the depth pointer alone decides which entries are meaningful.
   always_ff @(posedge iclk) begin
      if (iwe) begin
         mem[iwaddr] <= iwdata;
      end
   end

   assign ordata = mem[iraddr];

endmodule

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - live status flags with masked writes and a LIFO shadow stack (optional parity: FLAG_STACK_PARITY_EN)
module flag_stack
   import cpu_pkg::*;
#(
   parameter int FLAG_W = FLAG_W_DEF,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              iclf,
   input  logic              ien,
   input  logic [FLAG_W-1:0] iwmask,
   input  logic [FLAG_W-1:0] iflag,
   input  logic              ipush,
   input  logic              ipop,
   input  logic              iclr_err,
   input  logic              iforce_carry,
   output logic [FLAG_W-1:0] oflag,
   output logic              ocarry,
   output logic [CNT_W-1:0]  odepth,
   output logic              oempty,
   output logic              ofull,
   output logic              oerr_ovf,
   output logic              oerr_udf
`ifdef FLAG_STACK_PARITY_EN
   ,
   output logic              oerr_par
`endif
);

`ifdef FLAG_STACK_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif
   localparam int ENTRY_W = FLAG_W + PAR_W;
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FLAG_W-1:0]  flag_q;
   logic [CNT_W-1:0]   depth_q;
   logic               ovf_q;
   logic               udf_q;

   logic               is_empty;
   logic               is_full;
   logic               xchg;
   logic               do_push;
   logic               do_pop;
   logic               rd_valid;
   logic               ovf_set;
   logic               udf_set;
   logic               mem_we;
   logic [CNT_W-1:0]   top_idx;
   logic [AW-1:0]      rd_addr;
   logic [AW-1:0]      wr_addr;
   logic [ENTRY_W-1:0] wr_data;
   logic [ENTRY_W-1:0] rd_data;
   logic [FLAG_W-1:0]  rd_flag;

   assign is_empty = (depth_q == '0);
   assign is_full  = (depth_q == CNT_W'(DEPTH));

   // Decode push/pop/exchange requests against the current stack occupancy.
   always_comb begin
      xchg     = ipush & ipop & ~is_empty;
      do_push  = ipush & ~xchg & ~is_full;
      do_pop   = ipop & ~ipush & ~is_empty;
      rd_valid = xchg | do_pop;
      ovf_set  = ipush & ~ipop & is_full;
      udf_set  = ipop & is_empty;
      mem_we   = do_push | xchg;
      top_idx  = depth_q - 1'b1;
      rd_addr  = AW'(top_idx);
      wr_addr  = xchg ? rd_addr : AW'(depth_q);
   end

`ifdef FLAG_STACK_PARITY_EN
   logic par_q;
   logic par_bad;

   assign wr_data  = {^flag_q, flag_q};
   assign rd_flag  = rd_data[FLAG_W-1:0];
   assign par_bad  = rd_valid & (^rd_data);
   assign oerr_par = par_q;

   // Sticky parity error; a detection in the same cycle as a clear keeps the bit set.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         par_q <= 1'b0;
      end else if (par_bad) begin
         par_q <= 1'b1;
      end else if (iclr_err) begin
         par_q <= 1'b0;
      end
   end
`else
   assign wr_data = flag_q;
   assign rd_flag = rd_data;
`endif

   flag_stack_mem #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W),
      .AW    (AW)
   ) u_mem (
      .iclk   (iclk),
      .iwe    (mem_we),
      .iwaddr (wr_addr),
      .iwdata (wr_data),
      .iraddr (rd_addr),
      .ordata (rd_data)
   );

   // Live flags: clear beats a restore, which beats a masked ALU write.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         flag_q <= '0;
      end else if (iclf) begin
         flag_q <= '0;
      end else if (rd_valid) begin
         flag_q <= rd_flag;
      end else if (ien) begin
         flag_q <= (flag_q & ~iwmask) | (iflag & iwmask);
      end
   end

   // Stack pointer; an exchange leaves it unchanged.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         depth_q <= '0;
      end else if (do_push) begin
         depth_q <= depth_q + 1'b1;
      end else if (do_pop) begin
         depth_q <= depth_q - 1'b1;
      end
   end

   // Sticky overflow/underflow flags; a set event outranks a clear in the same cycle.
   always_ff @(posedge iclk) begin
      if (!irst_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_set | (ovf_q & ~iclr_err);
         udf_q <= udf_set | (udf_q & ~iclr_err);
      end
   end

   assign oflag    = flag_q;
   assign ocarry   = iforce_carry ? 1'b0 : flag_q[FLAG_CARRY_IDX];
   assign odepth   = depth_q;
   assign oempty   = is_empty;
   assign ofull    = is_full;
   assign oerr_ovf = ovf_q;
   assign oerr_udf = udf_q;

endmodule
